// File: rtl/vend_ctrl_multi_pkg.sv
// ---------------------------------------------------------------------------
// vend_ctrl_multi_pkg
// Shared definitions for the multi-slot vending controller:
//   - state_t     : controller FSM state encoding
//   - COIN_*      : coin code constants
//   - coin_value(): coin code -> monetary value (8-bit)
// ---------------------------------------------------------------------------
package vend_ctrl_multi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_VEND    = 2'd2,
      ST_REFUND  = 2'd3
   } state_t;

   localparam logic [2:0] COIN_0   = 3'd0;
   localparam logic [2:0] COIN_1   = 3'd1;
   localparam logic [2:0] COIN_2   = 3'd2;
   localparam logic [2:0] COIN_5   = 3'd3;
   localparam logic [2:0] COIN_10  = 3'd4;
   localparam logic [2:0] COIN_20  = 3'd5;
   localparam logic [2:0] COIN_50  = 3'd6;
   localparam logic [2:0] COIN_100 = 3'd7;

   function automatic logic [7:0] coin_value(input logic [2:0] code);
      logic [7:0] v;
      case (code)
         COIN_0:   v = 8'd0;
         COIN_1:   v = 8'd1;
         COIN_2:   v = 8'd2;
         COIN_5:   v = 8'd5;
         COIN_10:  v = 8'd10;
         COIN_20:  v = 8'd20;
         COIN_50:  v = 8'd50;
         COIN_100: v = 8'd100;
         default:  v = 8'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vend_ctrl_multi_stock_bank.sv
// ---------------------------------------------------------------------------
// vend_ctrl_multi_stock_bank
// N_ITEMS per-slot stock counters with registered sold-out flags.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset (stock = INIT_STOCK)
//   i_dec_valid    : decrement stock of slot i_dec_sel (never below zero)
//   i_rs_valid     : add i_rs_qty to slot i_rs_sel, saturating at all-ones
//   o_sold_out[i]  : slot i stock is zero (updated together with the stock)
// ---------------------------------------------------------------------------
module vend_ctrl_multi_stock_bank
   import vend_ctrl_multi_pkg::*;
#(
   parameter int N_ITEMS    = 4,
   parameter int SEL_W      = $clog2(N_ITEMS),
   parameter int STOCK_W    = 4,
   parameter int INIT_STOCK = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_dec_valid,
   input  logic [SEL_W-1:0]   i_dec_sel,
   input  logic               i_rs_valid,
   input  logic [SEL_W-1:0]   i_rs_sel,
   input  logic [STOCK_W-1:0] i_rs_qty,
   output logic [N_ITEMS-1:0] o_sold_out
);

   logic [STOCK_W-1:0] r_stock     [N_ITEMS];
   logic [STOCK_W-1:0] w_stock_nxt [N_ITEMS];
   logic [STOCK_W:0]   w_rs_sum    [N_ITEMS];
   logic [N_ITEMS-1:0] r_sold_out;

   // Next stock per slot: decrement on sale, saturating add on restock
   always_comb begin
      for (int i = 0; i < N_ITEMS; i++) begin
         w_stock_nxt[i] = r_stock[i];
         w_rs_sum[i]    = {1'b0, r_stock[i]} + {1'b0, i_rs_qty};
         if (i_dec_valid && (i_dec_sel == SEL_W'(i)) && (r_stock[i] != {STOCK_W{1'b0}})) begin
            w_stock_nxt[i] = r_stock[i] - {{(STOCK_W-1){1'b0}}, 1'b1};
         end else if (i_rs_valid && (i_rs_sel == SEL_W'(i))) begin
            w_stock_nxt[i] = w_rs_sum[i][STOCK_W] ? {STOCK_W{1'b1}} : w_rs_sum[i][STOCK_W-1:0];
         end else begin
            w_stock_nxt[i] = r_stock[i];
         end
      end
   end

   // Stock counters and sold-out flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            r_stock[i]    <= STOCK_W'(INIT_STOCK);
            r_sold_out[i] <= (INIT_STOCK == 0);
         end
      end else begin
         for (int i = 0; i < N_ITEMS; i++) begin
            r_stock[i]    <= w_stock_nxt[i];
            r_sold_out[i] <= (w_stock_nxt[i] == {STOCK_W{1'b0}});
         end
      end
   end

   assign o_sold_out = r_sold_out;

endmodule

// File: rtl/vend_ctrl_multi.sv
// ---------------------------------------------------------------------------
// vend_ctrl_multi
// Multi-slot vending controller: coin credit accumulation, multi-purchase
// sessions, per-slot stock and change return. All outputs registered.
// Optional feature macro: VEND_RESTOCK_EN (adds restock_valid/item/qty ports,
// restocking allowed in IDLE only).
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : open a session (IDLE only)
//   coin_valid, coin      : coin strobe and code
//   item_sel, done_money  : purchase request for slot item_sel
//   continue_buy          : sampled in VEND, keep session open
//   cancel                : abort and refund whole credit
//   item_out              : one-hot dispense pulse
//   done, change          : session end pulse with returned amount
//   credit                : current credit
//   sold_out              : per-slot empty flags
//   err_pulse             : rejected coin/request pulse
//   busy                  : session in progress
// MONEY_W must be at least 8 (coin values up to 100).
// ---------------------------------------------------------------------------
module vend_ctrl_multi
   import vend_ctrl_multi_pkg::*;
#(
   parameter int                         N_ITEMS     = 4,
   parameter int                         SEL_W       = $clog2(N_ITEMS),
   parameter int                         MONEY_W     = 8,
   parameter int                         STOCK_W     = 4,
   parameter int                         INIT_STOCK  = 5,
   parameter logic [N_ITEMS*MONEY_W-1:0] PRICE_TABLE = {8'd25, 8'd20, 8'd15, 8'd10}
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               coin_valid,
   input  logic [2:0]         coin,
   input  logic [SEL_W-1:0]   item_sel,
   input  logic               done_money,
   input  logic               continue_buy,
   input  logic               cancel,
`ifdef VEND_RESTOCK_EN
   input  logic               restock_valid,
   input  logic [SEL_W-1:0]   restock_item,
   input  logic [STOCK_W-1:0] restock_qty,
`endif
   output logic [N_ITEMS-1:0] item_out,
   output logic               done,
   output logic [MONEY_W-1:0] change,
   output logic [MONEY_W-1:0] credit,
   output logic [N_ITEMS-1:0] sold_out,
   output logic               err_pulse,
   output logic               busy
);

   state_t             r_state, w_state_nxt;
   logic [MONEY_W-1:0] r_credit, w_credit_nxt;
   logic [N_ITEMS-1:0] r_item_out, w_item_nxt;
   logic               r_done, w_done_nxt;
   logic [MONEY_W-1:0] r_change, w_change_nxt;
   logic               r_err, w_err_nxt;
   logic               r_busy;

   logic [MONEY_W:0]   w_coin_sum;
   logic [MONEY_W-1:0] w_price;
   logic               w_sel_ok;
   logic               w_buy_ok;
   logic [N_ITEMS-1:0] w_onehot;
   logic [N_ITEMS-1:0] w_sold_out;
   logic               w_dec_valid;
   logic               w_rs_ok, w_rs_err;
   logic [SEL_W-1:0]   w_rs_sel;
   logic [STOCK_W-1:0] w_rs_qty;

   // The extra MSB of the sum flags a coin that would overflow the credit.
   assign w_coin_sum = {1'b0, r_credit} + {{(MONEY_W-7){1'b0}}, coin_value(coin)};
   assign w_price    = PRICE_TABLE[item_sel*MONEY_W +: MONEY_W];
   assign w_sel_ok   = ({{(32-SEL_W){1'b0}}, item_sel} < 32'(N_ITEMS));
   assign w_buy_ok   = w_sel_ok && !w_sold_out[item_sel] && (r_credit >= w_price);
   assign w_onehot   = {{(N_ITEMS-1){1'b0}}, 1'b1} << item_sel;

`ifdef VEND_RESTOCK_EN
   // Restock is only legal while idle and for an existing slot
   always_comb begin
      w_rs_ok  = 1'b0;
      w_rs_err = 1'b0;
      if (restock_valid) begin
         if ((r_state == ST_IDLE) && ({{(32-SEL_W){1'b0}}, restock_item} < 32'(N_ITEMS))) begin
            w_rs_ok = 1'b1;
         end else begin
            w_rs_err = 1'b1;
         end
      end else begin
         w_rs_ok = 1'b0;
      end
   end
   assign w_rs_sel = restock_item;
   assign w_rs_qty = restock_qty;
`else
   assign w_rs_ok  = 1'b0;
   assign w_rs_err = 1'b0;
   assign w_rs_sel = {SEL_W{1'b0}};
   assign w_rs_qty = {STOCK_W{1'b0}};
`endif

   // FSM next state, credit update and next values of the output registers
   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_item_nxt   = {N_ITEMS{1'b0}};
      w_done_nxt   = 1'b0;
      w_change_nxt = {MONEY_W{1'b0}};
      w_err_nxt    = 1'b0;
      w_dec_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_COLLECT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            // cancel > done_money > coin; a coin losing arbitration is rejected
            if (cancel) begin
               w_state_nxt  = ST_REFUND;
               w_done_nxt   = 1'b1;
               w_change_nxt = r_credit;
               w_err_nxt    = coin_valid;
            end else if (done_money) begin
               if (w_buy_ok) begin
                  w_state_nxt  = ST_VEND;
                  w_item_nxt   = w_onehot;
                  w_credit_nxt = r_credit - w_price;
                  w_dec_valid  = 1'b1;
                  w_err_nxt    = coin_valid;
               end else begin
                  w_err_nxt    = 1'b1;
               end
            end else if (coin_valid) begin
               if (w_coin_sum[MONEY_W]) begin
                  w_err_nxt    = 1'b1;
               end else begin
                  w_credit_nxt = w_coin_sum[MONEY_W-1:0];
               end
            end else begin
               w_state_nxt = ST_COLLECT;
            end
         end
         ST_VEND: begin
            if (continue_buy) begin
               w_state_nxt  = ST_COLLECT;
            end else begin
               w_state_nxt  = ST_REFUND;
               w_done_nxt   = 1'b1;
               w_change_nxt = r_credit;
            end
         end
         ST_REFUND: begin
            w_state_nxt  = ST_IDLE;
            w_credit_nxt = {MONEY_W{1'b0}};
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_credit_nxt = {MONEY_W{1'b0}};
         end
      endcase
   end

   // State, credit and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_credit   <= {MONEY_W{1'b0}};
         r_item_out <= {N_ITEMS{1'b0}};
         r_done     <= 1'b0;
         r_change   <= {MONEY_W{1'b0}};
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_credit   <= w_credit_nxt;
         r_item_out <= w_item_nxt;
         r_done     <= w_done_nxt;
         r_change   <= w_change_nxt;
         r_err      <= w_err_nxt | w_rs_err;
         r_busy     <= (w_state_nxt != ST_IDLE);
      end
   end

   vend_ctrl_multi_stock_bank #(
      .N_ITEMS    (N_ITEMS),
      .SEL_W      (SEL_W),
      .STOCK_W    (STOCK_W),
      .INIT_STOCK (INIT_STOCK)
   ) u_stock (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_dec_valid (w_dec_valid),
      .i_dec_sel   (item_sel),
      .i_rs_valid  (w_rs_ok),
      .i_rs_sel    (w_rs_sel),
      .i_rs_qty    (w_rs_qty),
      .o_sold_out  (w_sold_out)
   );

   assign item_out  = r_item_out;
   assign done      = r_done;
   assign change    = r_change;
   assign credit    = r_credit;
   assign sold_out  = w_sold_out;
   assign err_pulse = r_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
module tb_vend_ctrl_multi;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start, coin_valid, done_money, continue_buy, cancel;
   logic [2:0] coin;
   logic [1:0] item_sel;
   logic [3:0] item_out, sold_out;
   logic       done, err_pulse, busy;
   logic [7:0] change, credit;
`ifdef VEND_RESTOCK_EN
   logic       restock_valid;
   logic [1:0] restock_item;
   logic [3:0] restock_qty;
`endif

   vend_ctrl_multi dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .coin_valid   (coin_valid),
      .coin         (coin),
      .item_sel     (item_sel),
      .done_money   (done_money),
      .continue_buy (continue_buy),
      .cancel       (cancel),
`ifdef VEND_RESTOCK_EN
      .restock_valid(restock_valid),
      .restock_item (restock_item),
      .restock_qty  (restock_qty),
`endif
      .item_out     (item_out),
      .done         (done),
      .change       (change),
      .credit       (credit),
      .sold_out     (sold_out),
      .err_pulse    (err_pulse),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: session flag, credit and stock as plain integers
   int m_credit;
   int m_stock [4];
   bit m_open;
   int price_tab [4] = '{10, 15, 20, 25};
   int coin_tab  [8] = '{0, 1, 2, 5, 10, 20, 50, 100};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] exp_sold();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (m_stock[i] == 0);
      return r;
   endfunction

   task automatic idle_inputs();
      start = 1'b0; coin_valid = 1'b0; coin = 3'd0; item_sel = 2'd0;
      done_money = 1'b0; continue_buy = 1'b0; cancel = 1'b0;
`ifdef VEND_RESTOCK_EN
      restock_valid = 1'b0; restock_item = 2'd0; restock_qty = 4'd0;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic t_reset();
      idle_inputs();
      reset_n = 1'b0;
      #2;
      m_open = 1'b0; m_credit = 0;
      for (int i = 0; i < 4; i++) m_stock[i] = 5;
      check("rst_item_out", item_out, 0);
      check("rst_done", done, 0);
      check("rst_change", change, 0);
      check("rst_credit", credit, 0);
      check("rst_err", err_pulse, 0);
      check("rst_busy", busy, 0);
      check("rst_sold_out", sold_out, exp_sold());
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic t_start();
      start = 1'b1;
      tick();
      idle_inputs();
      m_open = 1'b1;
      check("start_busy", busy, 1);
      check("start_err", err_pulse, 0);
      check("start_credit", credit, m_credit);
   endtask

   task automatic t_coin(input int code);
      bit rej;
      coin_valid = 1'b1; coin = code[2:0];
      tick();
      idle_inputs();
      rej = 1'b0;
      if (m_open) begin
         if (m_credit + coin_tab[code] > 255) rej = 1'b1;
         else m_credit = m_credit + coin_tab[code];
      end
      check("coin_err", err_pulse, rej);
      check("coin_credit", credit, m_credit);
      check("coin_busy", busy, m_open);
   endtask

   task automatic t_buy(input int sel, input bit cont, input bit coin_too);
      bit ok;
      done_money = 1'b1; item_sel = sel[1:0];
      coin_valid = coin_too; coin = 3'($urandom_range(0, 7));
      tick();
      idle_inputs();
      if (!m_open) begin
         check("idle_buy_item", item_out, 0);
         check("idle_buy_err", err_pulse, 0);
         check("idle_buy_busy", busy, 0);
      end else begin
         ok = (m_stock[sel] > 0) && (m_credit >= price_tab[sel]);
         if (ok) begin
            m_credit = m_credit - price_tab[sel];
            m_stock[sel]--;
            check("buy_item_out", item_out, 4'b0001 << sel);
            check("buy_err", err_pulse, coin_too);
            check("buy_credit", credit, m_credit);
            check("buy_sold_out", sold_out, exp_sold());
            continue_buy = cont;
            tick();
            idle_inputs();
            check("vend_item_clr", item_out, 0);
            check("vend_credit", credit, m_credit);
            if (cont) begin
               check("cont_done", done, 0);
               check("cont_busy", busy, 1);
            end else begin
               check("end_done", done, 1);
               check("end_change", change, m_credit);
               tick();
               m_credit = 0; m_open = 1'b0;
               check("post_done", done, 0);
               check("post_change", change, 0);
               check("post_credit", credit, 0);
               check("post_busy", busy, 0);
            end
         end else begin
            check("rej_err", err_pulse, 1);
            check("rej_item_out", item_out, 0);
            check("rej_credit", credit, m_credit);
            check("rej_busy", busy, 1);
         end
      end
   endtask

   task automatic t_cancel(input bit dm_too, input bit coin_too);
      cancel = 1'b1; done_money = dm_too; item_sel = 2'($urandom_range(0, 3));
      coin_valid = coin_too; coin = 3'($urandom_range(0, 7));
      tick();
      idle_inputs();
      if (!m_open) begin
         check("idle_cancel_done", done, 0);
         check("idle_cancel_err", err_pulse, 0);
      end else begin
         check("cancel_done", done, 1);
         check("cancel_change", change, m_credit);
         check("cancel_err", err_pulse, coin_too);
         check("cancel_item", item_out, 0);
         tick();
         m_credit = 0; m_open = 1'b0;
         check("cancel_post_done", done, 0);
         check("cancel_post_credit", credit, 0);
         check("cancel_post_busy", busy, 0);
      end
      check("cancel_sold_out", sold_out, exp_sold());
   endtask

`ifdef VEND_RESTOCK_EN
   task automatic t_restock(input int sel, input int qty);
      restock_valid = 1'b1; restock_item = sel[1:0]; restock_qty = qty[3:0];
      tick();
      idle_inputs();
      if (!m_open) m_stock[sel] = (m_stock[sel] + qty > 15) ? 15 : m_stock[sel] + qty;
      check("restock_err", err_pulse, m_open);
      check("restock_sold_out", sold_out, exp_sold());
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      repeat (2) @(posedge clk);
      t_reset();

      // Exact-price purchase of slot 3, no change
      t_start(); t_coin(4); t_coin(4); t_coin(3);
      t_buy(3, 1'b0, 1'b0);

      // Two purchases in one session
      t_start(); t_coin(5); t_coin(4);
      t_buy(0, 1'b1, 1'b0);
      check("t2_credit20", credit, 20);
      t_buy(1, 1'b0, 1'b0);

      // Insufficient credit, then cancel refunds 10
      t_start(); t_coin(4);
      t_buy(2, 1'b0, 1'b0);
      t_cancel(1'b0, 1'b0);

      // Drain slot 0 then attempt a sixth purchase
      t_reset();
      t_start(); t_coin(6); t_coin(4);
      repeat (5) t_buy(0, 1'b1, 1'b0);
      check("t4_sold0", sold_out[0], 1);
      t_buy(0, 1'b1, 1'b0);
      t_cancel(1'b0, 1'b0);

      // Credit overflow boundary and triple-request priority
      t_reset();
      t_start(); t_coin(7); t_coin(7); t_coin(6);
      t_coin(4);
      t_coin(3);
      check("t5_credit255", credit, 255);
      t_coin(1);
      t_cancel(1'b1, 1'b1);

      // Inputs ignored while idle, start ignored in session, zero cancel
      t_coin(5); t_buy(1, 1'b0, 1'b0); t_cancel(1'b0, 1'b0);
      t_start(); t_start(); t_coin(0);
      t_cancel(1'b0, 1'b0);

      // Reset while dispensing
      t_start(); t_coin(4);
      done_money = 1'b1; item_sel = 2'd0;
      tick();
      idle_inputs();
      check("t6_item_vend", item_out, 4'b0001);
      t_reset();

`ifdef VEND_RESTOCK_EN
      t_restock(3, 15);
      t_start(); t_restock(2, 3); t_cancel(1'b0, 1'b0);
`endif

      // Randomized sessions against the model
      for (int s = 0; s < 150; s++) begin
         if ($urandom_range(0, 19) == 0) t_reset();
         t_start();
         for (int k = 0; k < 10 && m_open; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) t_coin($urandom_range(0, 7));
            else if (r < 9) t_buy($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                                  ($urandom_range(0, 7) == 0));
            else t_cancel(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         if (m_open) t_cancel(1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
